hazard_scoreboard: RTL

Parametrised register-hazard scoreboard that replaces the flag-vector stall logic between the ID stage and the long-latency execution units (multiplier, divider, load path). It tracks outstanding writes per architectural register with small counters rather than single flags, so several in-flight writes to the same rd are counted correctly. It also enforces per-unit occupancy limits and optionally releases a stall in the same cycle a blocking writeback retires. It drives the single stall line into pipeline control and sits alongside the ID/EX boundary.

---
 rtl/hazard_scoreboard_pkg.sv | 24 ++
 rtl/sb_counter.sv | 46 ++++
 rtl/hazard_scoreboard.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared unit codes and helpers for the register-hazard scoreboard.
package hazard_pkg;

  // Unit codes carried on id_unit_i; ALU ops complete in one cycle and are not tracked.
  localparam int unsigned UNIT_ALU  = 0;
  localparam int unsigned UNIT_MUL  = 1;
  localparam int unsigned UNIT_DIV  = 2;
  localparam int unsigned UNIT_LOAD = 3;

  // Upper bound on the flattened writeback-address bus handled by wb_field.
  localparam int unsigned WB_FLAT_MAX = 256;

  // Extract field idx (zero-based) of width aw from a flattened address bus.
  function automatic logic [31:0] wb_field(input logic [WB_FLAT_MAX-1:0] flat,
                                           input int unsigned idx,
                                           input int unsigned aw);
    logic [WB_FLAT_MAX-1:0] shifted;
    logic [WB_FLAT_MAX-1:0] mask;
    shifted = flat >> (idx * aw);
    mask    = (WB_FLAT_MAX'(1) << aw) - WB_FLAT_MAX'(1);
    return 32'(shifted & mask);
  endfunction

endpackage

// File: rtl/sb_counter.sv
// Saturating up/down counter: one increment and a multi-count decrement per cycle.
// A net result below zero clamps to zero and raises uflow_o for that cycle.
module sb_counter #(
  parameter int unsigned W  = 2,
  parameter int unsigned DW = 2
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          inc_i,
  input  logic [DW-1:0] dec_i,
  output logic [W-1:0]  cnt_o,
  output logic          uflow_o
);

  localparam int MaxVal = (1 << W) - 1;

  logic [W-1:0] cnt_q, cnt_d;
  int           net;

  // Net update with clamping at both ends.
  always_comb begin
    cnt_d   = cnt_q;
    uflow_o = 1'b0;
    net     = int'(cnt_q) + int'(inc_i) - int'(dec_i);
    if (net < 0) begin
      cnt_d   = '0;
      uflow_o = 1'b1;
    end else if (net > MaxVal) begin
      cnt_d = W'(MaxVal);
    end else begin
      cnt_d = W'(net);
    end
  end

  // Counter state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Register-hazard scoreboard between ID and the long-latency units. Counts in-flight
// writes per architectural register and in-flight ops per unit, and raises stall.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned NREG       = 32,
  parameter int unsigned AW         = 5,
  parameter int unsigned NUNIT      = 3,
  parameter int unsigned UW         = 2,
  parameter int unsigned CNT_W      = 2,
  parameter int unsigned UNIT_DEPTH = 4,
  parameter bit          WB_BYPASS  = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid_i,
  input  logic [UW-1:0]       id_unit_i,
  input  logic                rs1_re_id_i,
  input  logic [AW-1:0]       rs1_addr_id_i,
  input  logic                rs2_re_id_i,
  input  logic [AW-1:0]       rs2_addr_id_i,
  input  logic                rd_we_id_i,
  input  logic [AW-1:0]       rd_addr_id_i,
  input  logic                flush_i,
  input  logic [NUNIT-1:0]    wb_valid_i,
  input  logic [NUNIT*AW-1:0] wb_addr_i,
  output logic                stall,
  output logic                pending_any_o,
  output logic [NUNIT-1:0]    unit_busy_o,
  output logic                err_o,
  output logic [31:0]         stall_cycles_o
);

  localparam int unsigned OCC_W = $clog2(UNIT_DEPTH + 1);
  localparam int unsigned HIT_W = $clog2(NUNIT + 1);
  localparam logic [CNT_W-1:0] PEND_MAX = '1;
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(UNIT_DEPTH);

  logic [WB_FLAT_MAX-1:0] wb_flat;
  logic [AW-1:0]          wb_rd      [NUNIT];
  logic [HIT_W-1:0]       wb_hits    [1:NREG-1];
  logic [CNT_W-1:0]       pend       [NREG];
  logic [NREG-1:1]        pend_inc;
  logic [NREG-1:1]        pend_uflow;
  logic [NREG-1:0]        haz;
  logic [OCC_W-1:0]       occ        [NUNIT];
  logic [NUNIT-1:0]       occ_inc;
  logic [NUNIT-1:0]       occ_uflow;
  logic                   issue, tracked, unit_full, rd_sat;
  logic                   err_q, err_d;
  logic [31:0]            stall_cnt_q, stall_cnt_d;

  assign wb_flat = WB_FLAT_MAX'(wb_addr_i);

  // Split the flattened writeback bus into one rd per unit.
  always_comb begin
    for (int unsigned u = 0; u < NUNIT; u++) begin
      wb_rd[u] = AW'(wb_field(wb_flat, u, AW));
    end
  end

  // Per-register count of writebacks retiring this cycle; x0 is never counted.
  always_comb begin
    for (int unsigned r = 1; r < NREG; r++) begin
      wb_hits[r] = '0;
      for (int unsigned u = 0; u < NUNIT; u++) begin
        if (wb_valid_i[u] && (wb_rd[u] == AW'(r))) begin
          wb_hits[r] = wb_hits[r] + HIT_W'(1);
        end
      end
    end
  end

  // Effective hazard per register; bypass lets retiring writebacks clear it early.
  always_comb begin
    haz = '0;
    for (int unsigned r = 1; r < NREG; r++) begin
      if (WB_BYPASS) begin
        haz[r] = 32'(pend[r]) > 32'(wb_hits[r]);
      end else begin
        haz[r] = (pend[r] != '0);
      end
    end
  end

  // Stall decision and the resulting issue strobe.
  always_comb begin
    tracked   = (id_unit_i != UW'(UNIT_ALU));
    unit_full = 1'b0;
    for (int unsigned u = 0; u < NUNIT; u++) begin
      if (id_unit_i == UW'(u + 1)) begin
        unit_full = unit_busy_o[u];
      end
    end
    // Counter saturation uses raw pend: a bypassed retirement cannot free a slot yet.
    rd_sat = rd_we_id_i && (rd_addr_id_i != '0) && (pend[rd_addr_id_i] == PEND_MAX);
    stall  = id_valid_i && ((rs1_re_id_i && haz[rs1_addr_id_i]) ||
                            (rs2_re_id_i && haz[rs2_addr_id_i]) ||
                            (rd_we_id_i  && haz[rd_addr_id_i])  ||
                            (tracked && (rd_sat || unit_full)));
    issue  = id_valid_i && !stall && !flush_i;
  end

  // Increment strobes for register and unit counters.
  always_comb begin
    for (int unsigned r = 1; r < NREG; r++) begin
      pend_inc[r] = issue && tracked && rd_we_id_i && (rd_addr_id_i == AW'(r));
    end
    for (int unsigned u = 0; u < NUNIT; u++) begin
      occ_inc[u] = issue && (id_unit_i == UW'(u + 1));
    end
  end

  assign pend[0] = '0;

  for (genvar r = 1; r < NREG; r++) begin : g_pend
    sb_counter #(
      .W  (CNT_W),
      .DW (HIT_W)
    ) u_pend (
      .clk_i   (clk),
      .rst_ni  (rst),
      .inc_i   (pend_inc[r]),
      .dec_i   (wb_hits[r]),
      .cnt_o   (pend[r]),
      .uflow_o (pend_uflow[r])
    );
  end

  for (genvar u = 0; u < NUNIT; u++) begin : g_occ
    sb_counter #(
      .W  (OCC_W),
      .DW (1)
    ) u_occ (
      .clk_i   (clk),
      .rst_ni  (rst),
      .inc_i   (occ_inc[u]),
      .dec_i   (wb_valid_i[u]),
      .cnt_o   (occ[u]),
      .uflow_o (occ_uflow[u])
    );
    assign unit_busy_o[u] = (occ[u] == OCC_FULL);
  end

  // Any register with an outstanding write.
  always_comb begin
    pending_any_o = 1'b0;
    for (int unsigned r = 1; r < NREG; r++) begin
      pending_any_o = pending_any_o | (pend[r] != '0);
    end
  end

  // Sticky error and free-running stall counter next-state.
  always_comb begin
    err_d       = err_q | (|pend_uflow) | (|occ_uflow);
    stall_cnt_d = stall_cnt_q + 32'(id_valid_i & stall);
  end

  // Status registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q       <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      err_q       <= err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign err_o          = err_q;
  assign stall_cycles_o = stall_cnt_q;

endmodule
